// File: rtl/ysyx_24070014_store_unit.sv
// NPC LSU store path: narrows and lane-replicates rs2, builds the byte strobe and runs one bus write.
// Optional macro STORE_MISALIGN_TRAP_EN: misaligned half/word stores complete with an error instead of aligning down.
module ysyx_24070014_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_bvalid,
  output logic        mem_bready,
  input  logic [1:0]  mem_bresp,
  output logic        done_valid,
  output logic        done_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_r, state_s;
  logic [31:0] waddr_r, wdata_r;
  logic [3:0]  wstrb_r;
  logic        wvalid_r, bready_r, done_valid_r, done_err_r;
  logic [31:0] cnt_r;
  logic        accept_s, bad_s, err_s, expired_s;
  logic [1:0]  off_s;

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << {off[1], 1'b0};
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  assign req_ready  = (state_r == IDLE);
  assign accept_s   = req_valid && (state_r == IDLE);
  assign expired_s  = (TIMEOUT_CYCLES != 32'd0) && ((cnt_r + 32'd1) >= TIMEOUT_CYCLES);
  assign mem_wvalid = wvalid_r;
  assign mem_bready = bready_r;
  assign mem_waddr  = waddr_r;
  assign mem_wdata  = wdata_r;
  assign mem_wstrb  = wstrb_r;
  assign done_valid = done_valid_r;
  assign done_err   = done_err_r;

  // Request legality and effective lane offset
  always_comb begin
    off_s = req_addr[1:0];
    bad_s = (req_size == 2'd3);
`ifdef STORE_MISALIGN_TRAP_EN
    if ((req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'b00)) begin
      bad_s = 1'b1;
    end else begin
      bad_s = (req_size == 2'd3);
    end
`else
    case (req_size)
      2'd1:    off_s = {req_addr[1], 1'b0};
      2'd2:    off_s = 2'b00;
      default: off_s = req_addr[1:0];
    endcase
`endif
  end

  // Next-state logic; a response arriving together with expiry takes priority
  always_comb begin
    state_s = state_r;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (bad_s) begin
            state_s = DONE;
            err_s   = 1'b1;
          end else begin
            state_s = WRITE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        if (mem_wready) begin
          state_s = RESP;
        end else if (expired_s) begin
          state_s = DONE;
          err_s   = 1'b1;
        end else begin
          state_s = WRITE;
        end
      end
      RESP: begin
        if (mem_bvalid) begin
          state_s = DONE;
          err_s   = (mem_bresp != 2'b00);
        end else if (expired_s) begin
          state_s = DONE;
          err_s   = 1'b1;
        end else begin
          state_s = RESP;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, registered handshake outputs and latched write beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      wvalid_r     <= 1'b0;
      bready_r     <= 1'b0;
      done_valid_r <= 1'b0;
      done_err_r   <= 1'b0;
      waddr_r      <= 32'd0;
      wdata_r      <= 32'd0;
      wstrb_r      <= 4'd0;
    end else begin
      state_r      <= state_s;
      wvalid_r     <= (state_s == WRITE);
      bready_r     <= (state_s == RESP);
      done_valid_r <= (state_s == DONE);
      done_err_r   <= (state_s == DONE) ? err_s : 1'b0;
      if (accept_s && !bad_s) begin
        waddr_r <= {req_addr[31:2], 2'b00};
        wdata_r <= lane_data(req_size, req_data);
        wstrb_r <= lane_strb(req_size, off_s);
      end else begin
        waddr_r <= waddr_r;
        wdata_r <= wdata_r;
        wstrb_r <= wstrb_r;
      end
    end
  end

  // Bus-wait counter: zero while idle, so it is clear on WRITE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 32'd0;
    end else if (state_r == IDLE) begin
      cnt_r <= 32'd0;
    end else if ((state_r == WRITE || state_r == RESP) && TIMEOUT_CYCLES != 32'd0) begin
      cnt_r <= cnt_r + 32'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_ysyx_24070014_store_unit.sv
// Scoreboard bench for the store unit: a default instance for data-path cases and a
// TIMEOUT_CYCLES=4 instance whose bus never answers.
module tb_ysyx_24070014_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = 32'd0, req_data = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        mem_wvalid, mem_wready = 1'b0;
  logic [31:0] mem_waddr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_bvalid = 1'b0, mem_bready;
  logic [1:0]  mem_bresp = 2'd0;
  logic        done_valid, done_err;

  logic        to_valid = 1'b0, to_ready, to_wvalid, to_bready, to_done, to_err;
  logic [31:0] to_waddr, to_wdata;
  logic [3:0]  to_wstrb;
  logic        zero1 = 1'b0;
  logic [1:0]  zero2 = 2'd0;

  int vecs = 0, miss = 0, cyc = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; int nwv; } wr_t;
  typedef struct { logic err; int lat; int nwv; } done_t;
  wr_t   wr_q[$];
  done_t done_q[$];
  done_t to_q[$];
  int    acc_q[$];

  ysyx_24070014_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_bvalid(mem_bvalid),
    .mem_bready(mem_bready), .mem_bresp(mem_bresp), .done_valid(done_valid), .done_err(done_err));

  ysyx_24070014_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .req_valid(to_valid), .req_ready(to_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_wvalid(to_wvalid), .mem_wready(zero1), .mem_waddr(to_waddr),
    .mem_wdata(to_wdata), .mem_wstrb(to_wstrb), .mem_bvalid(zero1),
    .mem_bready(to_bready), .mem_bresp(zero2), .done_valid(to_done), .done_err(to_err));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the default instance
  initial begin
    int wv = 0;
    logic [31:0] pa = 32'd0, pd = 32'd0;
    wr_t w;
    done_t e;
    int acc;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_q.delete();
        wv = 0;
      end else begin
        if (req_valid && req_ready) acc_q.push_back(cyc);
        if (mem_wvalid) begin
          if (wv > 0) begin
            chk("wvalid_stable_addr", mem_waddr, pa);
            chk("wvalid_stable_data", mem_wdata, pd);
          end
          wv++;
          pa = mem_waddr;
          pd = mem_wdata;
          if (mem_wready) begin
            if (wr_q.size() == 0) begin
              chk("unexpected_write", 32'd1, 32'd0);
            end else begin
              w = wr_q.pop_front();
              chk("waddr", mem_waddr, w.a);
              chk("wdata", mem_wdata, w.d);
              chk("wstrb", {28'd0, mem_wstrb}, {28'd0, w.s});
              chk("wvalid_cycles", wv, w.nwv);
            end
            wv = 0;
          end
        end
        if (done_valid) begin
          if (done_q.size() == 0 || acc_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = done_q.pop_front();
            acc = acc_q.pop_front();
            chk("done_err", {31'd0, done_err}, {31'd0, e.err});
            chk("done_latency", cyc - acc, e.lat);
          end
        end
      end
    end
  end

  // Monitor for the timeout instance
  initial begin
    int wv = 0;
    int acc = 0;
    done_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (to_valid && to_ready) begin
          acc = cyc;
          wv = 0;
        end
        if (to_wvalid) wv++;
        if (to_done) begin
          if (to_q.size() == 0) begin
            chk("to_unexpected_done", 32'd1, 32'd0);
          end else begin
            e = to_q.pop_front();
            chk("to_done_err", {31'd0, to_err}, {31'd0, e.err});
            chk("to_latency", cyc - acc, e.lat);
            chk("to_wvalid_cycles", wv, e.nwv);
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input int wwait, input logic [1:0] resp, input bit bus,
                       input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es,
                       input logic eerr, input int elat);
    wait_ready();
    if (bus) wr_q.push_back('{a: ea, d: ed, s: es, nwv: wwait + 1});
    done_q.push_back('{err: eerr, lat: elat, nwv: 0});
    req_addr = a; req_data = d; req_size = sz; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    if (bus) begin
      mem_wready = 1'b0;
      repeat (wwait) tick();
      mem_wready = 1'b1;
      tick();
      mem_wready = 1'b0;
      mem_bvalid = 1'b1;
      mem_bresp = resp;
      tick();
      mem_bvalid = 1'b0;
      mem_bresp = 2'd0;
    end
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wvalid", {31'd0, mem_wvalid}, 32'd0);
    chk("rst_bready", {31'd0, mem_bready}, 32'd0);
    chk("rst_done", {30'd0, done_valid, done_err}, 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    store(32'h8000_0003, 32'h1234_56AB, 2'd0, 0, 2'd0, 1'b1, 32'h8000_0000, 32'hABAB_ABAB, 4'b1000, 1'b0, 3);
    store(32'h8000_0002, 32'hDEAD_BEEF, 2'd1, 0, 2'd0, 1'b1, 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 1'b0, 3);
    store(32'h0000_0100, 32'hCAFE_F00D, 2'd2, 5, 2'd2, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'b1111, 1'b1, 8);
`ifdef STORE_MISALIGN_TRAP_EN
    store(32'h0000_0102, 32'h1122_3344, 2'd2, 0, 2'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1);
    store(32'h0000_0203, 32'h0000_7788, 2'd1, 0, 2'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1);
`else
    store(32'h0000_0102, 32'h1122_3344, 2'd2, 0, 2'd0, 1'b1, 32'h0000_0100, 32'h1122_3344, 4'b1111, 1'b0, 3);
    store(32'h0000_0203, 32'h0000_7788, 2'd1, 0, 2'd0, 1'b1, 32'h0000_0200, 32'h7788_7788, 4'b1100, 1'b0, 3);
`endif
    store(32'h0000_0200, 32'hFFFF_FFFF, 2'd3, 0, 2'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1);
    store(32'h0000_0001, 32'h0000_00C3, 2'd0, 0, 2'd1, 1'b1, 32'h0000_0000, 32'hC3C3_C3C3, 4'b0010, 1'b1, 3);
    store(32'h0000_0000, 32'h0000_A55A, 2'd1, 1, 2'd0, 1'b1, 32'h0000_0000, 32'hA55A_A55A, 4'b0011, 1'b0, 4);

    // stray response while idle must not produce a completion
    mem_bvalid = 1'b1;
    mem_bresp = 2'd3;
    repeat (2) tick();
    mem_bvalid = 1'b0;
    mem_bresp = 2'd0;
    tick();

    // silent bus on the short-timeout instance
    to_q.push_back('{err: 1'b1, lat: 5, nwv: 4});
    req_addr = 32'h0000_0040; req_data = 32'h0102_0304; req_size = 2'd2;
    to_valid = 1'b1;
    tick();
    to_valid = 1'b0;
    repeat (8) tick();

    // reset while in RESP
    wait_ready();
    wr_q.push_back('{a: 32'h0000_0300, d: 32'h0BAD_F00D, s: 4'b1111, nwv: 1});
    req_addr = 32'h0000_0300; req_data = 32'h0BAD_F00D; req_size = 2'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    mem_wready = 1'b1;
    tick();
    mem_wready = 1'b0;
    chk("resp_bready", {31'd0, mem_bready}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_bready", {31'd0, mem_bready}, 32'd0);
    chk("abort_wvalid", {31'd0, mem_wvalid}, 32'd0);
    chk("abort_done", {31'd0, done_valid}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    store(32'h0000_0304, 32'h5A5A_5A5A, 2'd2, 0, 2'd0, 1'b1, 32'h0000_0304, 32'h5A5A_5A5A, 4'b1111, 1'b0, 3);

    n = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0 || to_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("wr_q_drained", wr_q.size(), 32'd0);
    chk("done_q_drained", done_q.size(), 32'd0);
    chk("to_q_drained", to_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
